parity_frame_rx: RTL and testbench

Serial frame receiver that sits directly upstream of the even/odd parity checker. It samples a single-wire frame (start bit, DATA_W data bits LSB first, one parity bit, stop bit) on an external bit-rate strobe. It presents the recovered data word and parity bit in parallel, with a one-cycle valid pulse. It also flags parity and framing errors so the downstream checker and the control logic need no serial handling.

---
 rtl/parity_frame_rx_pkg.sv | 16 +
 rtl/parity_frame_rx_if.sv | 27 ++
 rtl/parity_frame_rx.sv | 116 +++++++++++
 tb/tb_parity_frame_rx.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/parity_frame_rx_pkg.sv
// Shared types and constants for the serial parity frame receiver.
package parity_frame_rx_pkg;

  // Receiver frame position; advances only on bit_tick.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_e;

  // Expected value of the XOR over data bits plus parity bit.
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/parity_frame_rx_if.sv
// Serial input and parallel result bundle of the parity frame receiver.
interface parity_frame_rx_if #(
  parameter int DATA_W = 4
) ();

  logic              rx_in;
  logic              bit_tick;
  logic [DATA_W-1:0] data_out;
  logic              parity_out;
  logic              frame_valid;
  logic              parity_err;
  logic              frame_err;
  logic              busy;

  // Line/strobe source and result consumer.
  modport master (
    output rx_in, bit_tick,
    input  data_out, parity_out, frame_valid, parity_err, frame_err, busy
  );

  // The receiver itself.
  modport slave (
    input  rx_in, bit_tick,
    output data_out, parity_out, frame_valid, parity_err, frame_err, busy
  );

endinterface

// File: rtl/parity_frame_rx.sv
// Serial frame receiver: start bit, DATA_W data bits LSB first, parity bit,
// stop bit, all sampled on bit_tick. Presents the word in parallel with
// one-cycle valid / parity-error / framing-error pulses.
module parity_frame_rx
  import parity_frame_rx_pkg::*;
#(
  parameter int DATA_W   = 4,
  parameter int ODD_MODE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  parity_frame_rx_if.slave rx_bus
);

  localparam int                CNT_W    = $clog2(DATA_W + 1);
  localparam logic              PAR_EXP  = (ODD_MODE != 0) ? PAR_ODD : PAR_EVEN;
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);

  rx_state_e         state_q,  state_d;
  logic [CNT_W-1:0]  cnt_q,    cnt_d;
  logic [DATA_W-1:0] shift_q,  shift_d;
  logic              par_q,    par_d;
  logic [DATA_W-1:0] data_q,   data_d;
  logic              parity_q, parity_d;
  logic              valid_q,  valid_d;
  logic              perr_q,   perr_d;
  logic              ferr_q,   ferr_d;

  // Next-state and datapath: everything holds unless bit_tick is high.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    par_d    = par_q;
    data_d   = data_q;
    parity_d = parity_q;
    valid_d  = 1'b0;
    perr_d   = 1'b0;
    ferr_d   = 1'b0;
    if (rx_bus.bit_tick) begin
      unique case (state_q)
        IDLE: begin
          if (!rx_bus.rx_in) begin
            cnt_d   = '0;
            state_d = DATA;
          end
        end
        DATA: begin
          shift_d = {rx_bus.rx_in, shift_q[DATA_W-1:1]};
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BIT) begin
            state_d = PARITY;
          end
        end
        PARITY: begin
          par_d   = rx_bus.rx_in;
          state_d = STOP;
        end
        STOP: begin
          // A low stop bit only flags the error; the low line is not
          // taken as the next start bit on this same tick.
          if (rx_bus.rx_in) begin
            data_d   = shift_q;
            parity_d = par_q;
            valid_d  = 1'b1;
            perr_d   = ((^{shift_q, par_q}) != PAR_EXP);
          end else begin
            ferr_d   = 1'b1;
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      data_q   <= '0;
      parity_q <= 1'b0;
      valid_q  <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      data_q   <= data_d;
      parity_q <= parity_d;
      valid_q  <= valid_d;
      perr_q   <= perr_d;
      ferr_q   <= ferr_d;
    end
  end

  assign rx_bus.data_out    = data_q;
  assign rx_bus.parity_out  = parity_q;
  assign rx_bus.frame_valid = valid_q;
  assign rx_bus.parity_err  = perr_q;
  assign rx_bus.frame_err   = ferr_q;
  assign rx_bus.busy        = (state_q != IDLE);

endmodule

// File: tb/tb_parity_frame_rx.sv
// Bench for parity_frame_rx: even and odd instances share one serial line.
module tb_parity_frame_rx;

  localparam int DW = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic rx;
  logic tick;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  parity_frame_rx_if #(.DATA_W(DW)) bus_e ();
  parity_frame_rx_if #(.DATA_W(DW)) bus_o ();

  assign bus_e.rx_in    = rx;
  assign bus_e.bit_tick = tick;
  assign bus_o.rx_in    = rx;
  assign bus_o.bit_tick = tick;

  parity_frame_rx #(.DATA_W(DW), .ODD_MODE(0)) dut_e (
    .clk(clk), .rst_n(rst_n), .rx_bus(bus_e)
  );
  parity_frame_rx #(.DATA_W(DW), .ODD_MODE(1)) dut_o (
    .clk(clk), .rst_n(rst_n), .rx_bus(bus_o)
  );

  typedef struct {
    logic [3:0] data;
    logic       par;
    logic       stop;
    int         gap;
    logic [3:0] exp_data;
    logic       exp_par;
    logic       exp_valid;
    logic       exp_perr_e;
    logic       exp_perr_o;
    logic       exp_ferr;
  } frame_vec_t;

  frame_vec_t tbl[7];

  // reference model state
  bit         m_busy;
  int         m_q[$];
  logic [3:0] m_data;
  logic       m_par;
  logic       m_valid, m_perr_e, m_perr_o, m_ferr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic b, input logic tk);
    rx   = b;
    tick = tk;
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input int gap);
    for (int i = 0; i < gap; i++) cyc(1'($urandom_range(0, 1)), 1'b0);
    cyc(b, 1'b1);
  endtask

  // Frame-level model: collect ticked samples after a low start sample,
  // then decode the whole frame arithmetically.
  task automatic model_step(input logic b, input logic tk);
    int w, ones;
    m_valid = 0; m_perr_e = 0; m_perr_o = 0; m_ferr = 0;
    if (tk) begin
      if (!m_busy) begin
        if (b == 1'b0) begin
          m_busy = 1;
          m_q.delete();
        end
      end else begin
        m_q.push_back(int'(b));
        if (m_q.size() == DW + 2) begin
          w = 0; ones = 0;
          for (int i = 0; i < DW; i++) begin
            w    += m_q[i] * (1 << i);
            ones += m_q[i];
          end
          ones += m_q[DW];
          if (m_q[DW + 1] == 1) begin
            m_data   = 4'(w);
            m_par    = 1'(m_q[DW]);
            m_valid  = 1;
            m_perr_e = ((ones % 2) != 0);
            m_perr_o = ((ones % 2) != 1);
          end else begin
            m_ferr = 1;
          end
          m_busy = 0;
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    int pcyc[2];
    logic [3:0] pdat[2];
    int bb[14];
    logic b, tk;

    tbl[0] = '{4'b0011, 1'b0, 1'b1, 0, 4'h3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{4'b0001, 1'b0, 1'b1, 1, 4'h1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{4'b1111, 1'b1, 1'b1, 2, 4'hF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{4'b1111, 1'b0, 1'b1, 0, 4'hF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{4'b0011, 1'b0, 1'b1, 1, 4'h3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{4'b0101, 1'b1, 1'b0, 1, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[6] = '{4'b1010, 1'b0, 1'b1, 3, 4'hA, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    rst_n = 1'b0;
    rx    = 1'b1;
    tick  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_e", {bus_e.data_out, bus_e.parity_out, bus_e.frame_valid,
                    bus_e.parity_err, bus_e.frame_err, bus_e.busy}, '0);
    chk("reset_o", {bus_o.data_out, bus_o.parity_out, bus_o.frame_valid,
                    bus_o.parity_err, bus_o.frame_err, bus_o.busy}, '0);
    rst_n = 1'b1;
    cyc(1'b1, 1'b1);

    // directed frame table
    for (int r = 0; r < 7; r++) begin
      send_bit(1'b0, tbl[r].gap);
      chk("busy_after_start", bus_e.busy, 1);
      for (int i = 0; i < DW; i++) send_bit(tbl[r].data[i], tbl[r].gap);
      send_bit(tbl[r].par, tbl[r].gap);
      chk("no_early_valid", bus_e.frame_valid, 0);
      send_bit(tbl[r].stop, tbl[r].gap);
      chk("data_e",   bus_e.data_out,    tbl[r].exp_data);
      chk("par_e",    bus_e.parity_out,  tbl[r].exp_par);
      chk("valid_e",  bus_e.frame_valid, tbl[r].exp_valid);
      chk("perr_e",   bus_e.parity_err,  tbl[r].exp_perr_e);
      chk("ferr_e",   bus_e.frame_err,   tbl[r].exp_ferr);
      chk("busy_end", bus_e.busy,        0);
      chk("data_o",   bus_o.data_out,    tbl[r].exp_data);
      chk("valid_o",  bus_o.frame_valid, tbl[r].exp_valid);
      chk("perr_o",   bus_o.parity_err,  tbl[r].exp_perr_o);
      chk("ferr_o",   bus_o.frame_err,   tbl[r].exp_ferr);
      cyc(1'b1, 1'b0);
      chk("pulse_width_e", {bus_e.frame_valid, bus_e.parity_err, bus_e.frame_err}, 0);
      chk("pulse_width_o", {bus_o.frame_valid, bus_o.parity_err, bus_o.frame_err}, 0);
    end

    // back-to-back frames, tick every cycle, no idle bit
    bb = '{0, 0, 1, 0, 1, 0, 1, 0, 0, 1, 1, 0, 0, 1};
    pulses = 0;
    for (int i = 0; i < 14; i++) begin
      cyc(1'(bb[i]), 1'b1);
      if (bus_e.frame_valid) begin
        if (pulses < 2) begin
          pcyc[pulses] = i;
          pdat[pulses] = bus_e.data_out;
        end
        pulses++;
      end
    end
    chk("b2b_pulses", pulses, 2);
    if (pulses == 2) begin
      chk("b2b_spacing", pcyc[1] - pcyc[0], 7);
      chk("b2b_data1", pdat[0], 4'b1010);
      chk("b2b_data2", pdat[1], 4'b0110);
    end
    cyc(1'b1, 1'b0);
    chk("b2b_idle", bus_e.busy, 0);

    // reset mid-DATA
    send_bit(1'b0, 0);
    send_bit(1'b1, 0);
    send_bit(1'b1, 0);
    chk("pre_reset_busy", bus_e.busy, 1);
    rst_n = 1'b0;
    #2;
    chk("midrst_e", {bus_e.data_out, bus_e.parity_out, bus_e.frame_valid,
                     bus_e.parity_err, bus_e.frame_err, bus_e.busy}, '0);
    chk("midrst_o", {bus_o.data_out, bus_o.parity_out, bus_o.frame_valid,
                     bus_o.parity_err, bus_o.frame_err, bus_o.busy}, '0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b1);
      chk("post_rst_quiet", {bus_e.frame_valid, bus_e.parity_err,
                             bus_e.frame_err, bus_e.busy}, 0);
    end

    // randomized stimulus against the frame-level model
    m_busy = 0;
    m_q.delete();
    m_data = '0;
    m_par  = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      tk = ($urandom_range(0, 2) != 0);
      b  = 1'($urandom_range(0, 1));
      cyc(b, tk);
      model_step(b, tk);
      chk("rand_e", {bus_e.data_out, bus_e.parity_out, bus_e.frame_valid,
                     bus_e.parity_err, bus_e.frame_err, bus_e.busy},
                    {m_data, m_par, m_valid, m_perr_e, m_ferr, m_busy});
      chk("rand_o", {bus_o.data_out, bus_o.parity_out, bus_o.frame_valid,
                     bus_o.parity_err, bus_o.frame_err, bus_o.busy},
                    {m_data, m_par, m_valid, m_perr_o, m_ferr, m_busy});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
